// File: rtl/sobel_window_engine_pkg.sv
// sobel_pkg: shared types and constants for the Sobel window engine.
//   state_t         - engine FSM states
//   ACC_W           - signed Gx/Gy accumulator width (|G| <= 1020 for 8-bit pixels)
//   MAG_MAX         - saturation ceiling of the output magnitude
//   GX_COEF/GY_COEF - Sobel kernels indexed by tap k = 3*dy' + dx' (raster order)
package sobel_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESULT} state_t;

  localparam int ACC_W   = 11;
  localparam int MAG_MAX = 255;

  typedef logic signed [2:0] coef_t;

  localparam coef_t GX_COEF [9] = '{-3'sd1,  3'sd0,  3'sd1,
                                    -3'sd2,  3'sd0,  3'sd2,
                                    -3'sd1,  3'sd0,  3'sd1};

  localparam coef_t GY_COEF [9] = '{-3'sd1, -3'sd2, -3'sd1,
                                     3'sd0,  3'sd0,  3'sd0,
                                     3'sd1,  3'sd2,  3'sd1};

endpackage

// File: rtl/sobel_window_engine_mag_sat.sv
// sobel_mag_sat: combinational gradient magnitude, min(|gx| + |gy|, MAG_MAX).
//   gx, gy : in  signed ACC_W-bit Sobel gradients
//   mag    : out PIX_W-bit saturated magnitude
module sobel_mag_sat
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic signed [ACC_W-1:0] gx,
  input  logic signed [ACC_W-1:0] gy,
  output logic        [PIX_W-1:0] mag
);

  function automatic logic [ACC_W-1:0] abs_val(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] neg;
    neg = -v;
    return v[ACC_W-1] ? $unsigned(neg) : $unsigned(v);
  endfunction

  function automatic logic [PIX_W-1:0] sat_mag(input logic [ACC_W:0] s);
    return (s > (ACC_W+1)'(MAG_MAX)) ? PIX_W'(MAG_MAX) : s[PIX_W-1:0];
  endfunction

  logic [ACC_W:0] sum;

  always_comb begin
    sum = {1'b0, abs_val(gx)} + {1'b0, abs_val(gy)};
    mag = sat_mag(sum);
  end

endmodule

// File: rtl/sobel_window_engine.sv
// sobel_window_engine: on each accepted start_calc pulse, fetches the next 3x3
// interior window in raster order, accumulates Sobel Gx/Gy and reports the
// saturated magnitude with a one-cycle start_sobel pulse.
//   clk, rst     - clock, synchronous active-high reset
//   start_calc   - request to process the next window (ignored while busy)
//   rd_en/rd_addr/rd_data - pixel memory read port, data 1 cycle after rd_en
//   busy         - high from FETCH through RESULT
//   start_sobel  - window result valid (one cycle)
//   mag_out      - min(|Gx|+|Gy|, 255), held until the next result
//   center_addr  - address of the window centre, held with mag_out
//   frame_done   - pulses with start_sobel on the last window of the frame
module sobel_window_engine
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 19,
  parameter int PIX_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calc,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              busy,
  output logic              start_sobel,
  output logic [PIX_W-1:0]  mag_out,
  output logic [ADDR_W-1:0] center_addr,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 2);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_HEIGHT - 2);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  state_t state, state_next;

  logic [3:0]              k;
  logic [3:0]              k_p1;
  logic                    vld_p1;
  logic [ADDR_W-1:0]       row, col;
  logic                    last_win;
  logic signed [ACC_W-1:0] gx, gy, gx_next, gy_next;
  logic signed [ACC_W-1:0] pix_s, cx, cy;
  logic [PIX_W-1:0]        mag_next;

  // Address of tap t of the window centred at (row, col); row, col >= 1 so
  // the -1 offsets never underflow.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [3:0] t);
    logic [ADDR_W-1:0] r, c;
    r = row - ONE_A + ADDR_W'(t / 4'd3);
    c = col - ONE_A + ADDR_W'(t % 4'd3);
    return r * W_A + c;
  endfunction

  assign last_win = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    start_sobel = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:   if (start_calc) state_next = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (k == 4'd8) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = RESULT;
      end
      RESULT: begin
        busy        = 1'b1;
        start_sobel = 1'b1;
        frame_done  = last_win;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: read issue. rd_en/rd_addr are registered so tap k is presented
  // during the FETCH cycle whose counter value is k; rd_addr holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_calc) begin
            rd_en   <= 1'b1;
            rd_addr <= tap_addr(4'd0);
            k       <= 4'd0;
          end
        end
        FETCH: begin
          if (k == 4'd8) begin
            rd_en <= 1'b0;
          end else begin
            rd_addr <= tap_addr(k + 4'd1);
            k       <= k + 4'd1;
          end
        end
        default: rd_en <= 1'b0;
      endcase
    end
  end

  // Stage p1: tap index travels with the returning read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      k_p1   <= '0;
    end else begin
      vld_p1 <= rd_en;
      k_p1   <= k;
    end
  end

  always_comb begin
    pix_s   = $signed({{(ACC_W-PIX_W){1'b0}}, rd_data});
    cx      = ACC_W'(GX_COEF[k_p1]);
    cy      = ACC_W'(GY_COEF[k_p1]);
    gx_next = gx;
    gy_next = gy;
    if (vld_p1) begin
      gx_next = gx + pix_s * cx;
      gy_next = gy + pix_s * cy;
    end
  end

  sobel_mag_sat #(.PIX_W(PIX_W)) u_mag_sat (
    .gx  (gx_next),
    .gy  (gy_next),
    .mag (mag_next)
  );

  // Stage p2: accumulate; the DRAIN edge folds in tap 8 and captures the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      gx          <= '0;
      gy          <= '0;
      mag_out     <= '0;
      center_addr <= '0;
    end else begin
      if (state == IDLE && start_calc) begin
        gx <= '0;
        gy <= '0;
      end else begin
        gx <= gx_next;
        gy <= gy_next;
      end
      if (state == DRAIN) begin
        mag_out     <= mag_next;
        center_addr <= row * W_A + col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= ONE_A;
      col <= ONE_A;
    end else if (state == RESULT) begin
      if (last_win) begin
        row <= ONE_A;
        col <= ONE_A;
      end else if (col == LAST_COL) begin
        col <= ONE_A;
        row <= row + ONE_A;
      end else begin
        col <= col + ONE_A;
      end
    end
  end

endmodule
